// File: rtl/serial_seq_tx_if.sv
// Handshake/serial bundle for serial_seq_tx.
//   start, data_in : request side, driven by the producer (master).
//   ready          : transmitter idle, start will be taken on the next edge.
//   dout           : serial bit stream, LSB first (feeds a sequence detector din).
//   dout_valid     : dout carries a frame bit this cycle.
//   done           : one-cycle pulse on the final bit of a frame.
interface serial_seq_tx_if #(
  parameter int unsigned DATA_W = 11
) ();
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              dout;
  logic              dout_valid;
  logic              done;

  modport master (
    output start, data_in,
    input  ready, dout, dout_valid, done
  );

  modport slave (
    input  start, data_in,
    output ready, dout, dout_valid, done
  );
endinterface

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: parallel-in, serial-out frame transmitter.
// Ports:
//   clk   : sole clock, rising edge.
//   reset : synchronous, active-high; wins over start.
//   bus   : serial_seq_tx_if.slave (start, data_in in; ready, dout,
//           dout_valid, done out). All outputs are registered.
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit
// (PAR state) after the DATA_W data bits; done then moves to that bit.
module serial_seq_tx #(
  parameter int unsigned DATA_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  serial_seq_tx_if.slave  bus
);

  // Counter must reach DATA_W (value after the last shift) without wrapping.
  localparam int unsigned       CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
`ifdef SEQ_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state/datapath; outputs are derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SEQ_TX_PARITY_EN
    par_d   = par_q;
`endif
    ready_d = 1'b0;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SEQ_TX_PARITY_EN
          par_d   = ^bus.data_in;
`endif
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PAR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    if (state_d == SHIFT) begin
      dout_d  = shreg_d[0];
      valid_d = 1'b1;
`ifndef SEQ_TX_PARITY_EN
      done_d  = (cnt_d == LAST);
`endif
    end
`ifdef SEQ_TX_PARITY_EN
    if (state_d == PAR) begin
      dout_d  = par_d;
      valid_d = 1'b1;
      done_d  = 1'b1;
    end
`endif
  end

  assign bus.ready      = ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: a DATA_W=11 instance and a DATA_W=1 instance
// share reset/start. A queue model predicts each cycle's outputs from the
// frame rules (bits LSB first, optional even parity, one frame at a time).
module tb_serial_seq_tx;

  localparam int unsigned W = 11;
`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLEN = int'(W) + int'(PAR_EN);

  logic clk;
  logic reset;

  serial_seq_tx_if #(.DATA_W(W)) bus_a ();
  serial_seq_tx_if #(.DATA_W(1)) bus_b ();

  serial_seq_tx #(.DATA_W(W)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  serial_seq_tx #(.DATA_W(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: pending bits of the frame on the wire.
  typedef struct packed { logic b; logic last; } mbit_t;
  typedef mbit_t mq_t[$];
  mq_t   qa, qb;
  mbit_t cur_a, cur_b;
  logic  cur_va = 1'b0;
  logic  cur_vb = 1'b0;

  typedef struct {
    logic         r;
    logic         s;
    logic [W-1:0] d;
    logic         e_ready;
    logic         e_dout;
    logic         e_valid;
    logic         e_done;
  } vec_t;
  vec_t tbl[$];

  function automatic void check(input string name, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic mq_t frame_bits(input logic [31:0] d, input int n);
    mq_t   q;
    mbit_t m;
    int    ones = 0;
    for (int i = 0; i < n; i++) begin
      m.b    = d[i];
      m.last = (i == n - 1) && (PAR_EN == 1'b0);
      q.push_back(m);
      ones += int'(d[i]);
    end
    if (PAR_EN) begin
      m.b    = (ones % 2) == 1;
      m.last = 1'b1;
      q.push_back(m);
    end
    return q;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic [W-1:0] d);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (!cur_va && s) qa = frame_bits(32'(d), int'(W));
      if (!cur_vb && s) qb = frame_bits(32'(d), 1);
    end
    if (qa.size() > 0) begin cur_a = qa.pop_front(); cur_va = 1'b1; end
    else begin cur_a = '0; cur_va = 1'b0; end
    if (qb.size() > 0) begin cur_b = qb.pop_front(); cur_vb = 1'b1; end
    else begin cur_b = '0; cur_vb = 1'b0; end
  endtask

  task automatic compare_model();
    check("a_ready", bus_a.ready,      !cur_va);
    check("a_dout",  bus_a.dout,       cur_va && cur_a.b);
    check("a_valid", bus_a.dout_valid, cur_va);
    check("a_done",  bus_a.done,       cur_va && cur_a.last);
    check("b_ready", bus_b.ready,      !cur_vb);
    check("b_dout",  bus_b.dout,       cur_vb && cur_b.b);
    check("b_valid", bus_b.dout_valid, cur_vb);
    check("b_done",  bus_b.done,       cur_vb && cur_b.last);
  endtask

  // Drive inputs, clock one edge, then compare at the falling edge.
  task automatic step(input logic r, input logic s, input logic [W-1:0] d);
    reset         = r;
    bus_a.start   = s;
    bus_a.data_in = d;
    bus_b.start   = s;
    bus_b.data_in = d[0];
    @(posedge clk);
    model_edge(r, s, d);
    @(negedge clk);
    compare_model();
  endtask

  task automatic add(input logic r, input logic s, input logic [W-1:0] d,
                     input logic er, input logic ed, input logic ev, input logic edn);
    vec_t v;
    v.r = r; v.s = s; v.d = d;
    v.e_ready = er; v.e_dout = ed; v.e_valid = ev; v.e_done = edn;
    tbl.push_back(v);
  endtask

  logic exp_bits [11];
  logic [W-1:0] rd;

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.data_in = '0;
    bus_b.start = 1'b0; bus_b.data_in = '0;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Basic frame 11'b10101001010, with a busy start of 11'h7FF mid-frame.
    add(1'b1, 1'b0, '0,                1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 11'b10101001010,   1'b0, exp_bits[0], 1'b1, 1'b0);
    for (int i = 1; i < 11; i++) begin
      if (i == 3) add(1'b0, 1'b1, 11'h7FF, 1'b0, exp_bits[i], 1'b1, 1'b0);
      else        add(1'b0, 1'b0, W'($urandom), 1'b0, exp_bits[i], 1'b1,
                      (i == 10) && !PAR_EN);
    end
    if (PAR_EN) add(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].s, tbl[k].d);
      check($sformatf("tbl%0d_ready", k), bus_a.ready,      tbl[k].e_ready);
      check($sformatf("tbl%0d_dout",  k), bus_a.dout,       tbl[k].e_dout);
      check($sformatf("tbl%0d_valid", k), bus_a.dout_valid, tbl[k].e_valid);
      check($sformatf("tbl%0d_done",  k), bus_a.done,       tbl[k].e_done);
    end

    // Back-to-back: start held from the done cycle, second frame 11'h001.
    step(1'b0, 1'b1, 11'h5A3);
    for (int i = 1; i < FLEN; i++) step(1'b0, 1'b0, '0);
    check("b2b_first_done", bus_a.done, 1'b1);
    step(1'b0, 1'b1, 11'h001);
    check("b2b_gap_valid", bus_a.dout_valid, 1'b0);
    check("b2b_gap_ready", bus_a.ready, 1'b1);
    step(1'b0, 1'b1, 11'h001);
    check("b2b_bit0_valid", bus_a.dout_valid, 1'b1);
    check("b2b_bit0_dout",  bus_a.dout, 1'b1);
    for (int i = 1; i < int'(W); i++) begin
      step(1'b0, 1'b0, 11'h7FF);
      check($sformatf("b2b_bit%0d_dout", i), bus_a.dout, 1'b0);
      check($sformatf("b2b_bit%0d_valid", i), bus_a.dout_valid, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

    // Mid-frame reset while bit 5 is on the wire.
    step(1'b0, 1'b1, 11'h3C5);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, '0);
    check("mid_busy", bus_a.dout_valid, 1'b1);
    step(1'b1, 1'b0, '0);
    check("rst_ready", bus_a.ready, 1'b1);
    check("rst_valid", bus_a.dout_valid, 1'b0);
    check("rst_done",  bus_a.done, 1'b0);
    for (int i = 0; i < FLEN; i++) begin
      step(1'b0, 1'b0, '0);
      check("abort_done",  bus_a.done, 1'b0);
      check("abort_valid", bus_a.dout_valid, 1'b0);
    end

    // Reset and start on the same edge.
    step(1'b1, 1'b1, 11'h7FF);
    check("coll_ready", bus_a.ready, 1'b1);
    check("coll_valid", bus_a.dout_valid, 1'b0);
    step(1'b0, 1'b0, '0);
    check("coll_stay_idle", bus_a.dout_valid, 1'b0);
    check("coll_b_idle",    bus_b.dout_valid, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      rd = W'($urandom);
      step(($urandom % 40) == 0, ($urandom % 3) == 0, rd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
